// File: rtl/peripheral_motion_ctrl_mc.sv
// Multi-channel step/direction motion controller on the 16-bit peripheral bus.
// Each channel runs an IDLE/HIGH/LOW pulse FSM; sticky done flags drive a maskable irq.
module peripheral_motion_ctrl_mc #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int PER_W   = 16,
    parameter int PULSE_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     d_in,
    input  logic            cs,
    input  logic [7:0]      addr,
    input  logic            rd,
    input  logic            wr,
    output logic [15:0]     d_out,
    output logic [N_CH-1:0] step,
    output logic [N_CH-1:0] dir,
    output logic [N_CH-1:0] busy,
    output logic            irq
);
    localparam int TMR_W = PER_W + 1;
    localparam logic [TMR_W-1:0] PULSE_TMR = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] MIN_PER   = TMR_W'(2 * PULSE_W);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_e;

    state_e           state_q  [N_CH];
    state_e           state_d  [N_CH];
    logic [TMR_W-1:0] tmr_q    [N_CH];
    logic [TMR_W-1:0] tmr_d    [N_CH];
    logic [TMR_W-1:0] p_eff    [N_CH];
    logic [CNT_W-1:0] steps_q  [N_CH];
    logic [CNT_W-1:0] steps_d  [N_CH];
    logic [CNT_W-1:0] remain_q [N_CH];
    logic [CNT_W-1:0] remain_d [N_CH];
    logic [PER_W-1:0] period_q [N_CH];
    logic [PER_W-1:0] period_d [N_CH];
    logic [N_CH-1:0]  dir_cfg_q, dir_cfg_d, dir_q, dir_d;
    logic [N_CH-1:0]  done_q, done_d, done_set, irq_en_q, irq_en_d;
    logic [15:0]      d_out_q, d_out_d, rdata;

    logic            wr_en, rd_en, ctrl_wr, abort;
    logic [N_CH-1:0] start_mask, done_clr;
    logic [4:0]      ch_idx;
    logic            ch_hit;
    logic            unused_addr0;

    assign wr_en        = cs & wr;
    assign rd_en        = cs & rd & ~wr;
    assign ctrl_wr      = wr_en && (addr[7:1] == 7'h00);
    assign abort        = ctrl_wr && d_in[15];
    assign start_mask   = (ctrl_wr && !d_in[15]) ? d_in[N_CH-1:0] : '0;
    assign done_clr     = (wr_en && (addr[7:1] == 7'h01)) ? d_in[N_CH-1:0] : '0;
    assign ch_idx       = addr[7:3] - 5'd2;
    assign ch_hit       = (addr[7:3] >= 5'd2) && (ch_idx < 5'(N_CH));
    assign unused_addr0 = addr[0];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch_out
        // Period shorter than two pulse widths is stretched so LOW is never shorter than HIGH.
        assign p_eff[g] = (TMR_W'(period_q[g]) < MIN_PER) ? MIN_PER : TMR_W'(period_q[g]);
        assign step[g]  = (state_q[g] == S_HIGH);
        assign busy[g]  = (state_q[g] != S_IDLE);
    end

    assign dir   = dir_q;
    assign irq   = |(done_q & irq_en_q);
    assign d_out = d_out_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        done_set  = '0;
        irq_en_d  = irq_en_q;
        dir_cfg_d = dir_cfg_q;
        dir_d     = dir_q;
        d_out_d   = d_out_q;
        rdata     = 16'h0000;

        case (addr[7:1])
            7'h00:   rdata = 16'(busy);
            7'h01:   rdata = 16'(done_q);
            7'h02:   rdata = 16'(irq_en_q);
            default: ;
        endcase
        if (wr_en && (addr[7:1] == 7'h02)) irq_en_d = d_in[N_CH-1:0];

        for (int k = 0; k < N_CH; k++) begin
            state_d[k]  = state_q[k];
            tmr_d[k]    = tmr_q[k];
            steps_d[k]  = steps_q[k];
            period_d[k] = period_q[k];
            remain_d[k] = remain_q[k];

            if (ch_hit && (ch_idx == 5'(k))) begin
                case (addr[2:1])
                    2'd0: rdata = 16'(steps_q[k]);
                    2'd1: rdata = 16'(period_q[k]);
                    2'd2: rdata = {15'd0, dir_cfg_q[k]};
                    default: rdata = 16'(remain_q[k]);
                endcase
                if (wr_en && (state_q[k] == S_IDLE)) begin
                    case (addr[2:1])
                        2'd0: steps_d[k]  = d_in[CNT_W-1:0];
                        2'd1: period_d[k] = d_in[PER_W-1:0];
                        2'd2: dir_cfg_d[k] = d_in[0];
                        default: ;
                    endcase
                end
            end

            case (state_q[k])
                S_IDLE: begin
                    if (start_mask[k]) begin
                        if (steps_q[k] != '0) begin
                            remain_d[k] = steps_q[k];
                            dir_d[k]    = dir_cfg_q[k];
                            state_d[k]  = S_HIGH;
                            tmr_d[k]    = PULSE_TMR;
                        end else begin
                            done_set[k] = 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    if (tmr_q[k] == '0) begin
                        state_d[k] = S_LOW;
                        tmr_d[k]   = p_eff[k] - TMR_W'(PULSE_W + 1);
                    end else begin
                        tmr_d[k] = tmr_q[k] - TMR_W'(1);
                    end
                end
                S_LOW: begin
                    if (tmr_q[k] == '0) begin
                        remain_d[k] = remain_q[k] - CNT_W'(1);
                        if (remain_q[k] == CNT_W'(1)) begin
                            state_d[k]  = S_IDLE;
                            done_set[k] = 1'b1;
                        end else begin
                            state_d[k] = S_HIGH;
                            tmr_d[k]   = PULSE_TMR;
                        end
                    end else begin
                        tmr_d[k] = tmr_q[k] - TMR_W'(1);
                    end
                end
                default: state_d[k] = S_IDLE;
            endcase

            // Abort overrides both a same-write start and a completing move.
            if (abort) begin
                state_d[k]  = S_IDLE;
                remain_d[k] = remain_q[k];
                dir_d[k]    = dir_q[k];
                done_set[k] = 1'b0;
            end
        end

        done_d = (done_q & ~done_clr) | done_set;
        if (rd_en) d_out_d = rdata;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the per-channel arrays are small configuration registers, so all are reset.
            for (int k = 0; k < N_CH; k++) begin
                state_q[k]  <= S_IDLE;
                tmr_q[k]    <= '0;
                steps_q[k]  <= '0;
                period_q[k] <= '0;
                remain_q[k] <= '0;
            end
            dir_cfg_q <= '0;
            dir_q     <= '0;
            done_q    <= '0;
            irq_en_q  <= '0;
            d_out_q   <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                state_q[k]  <= state_d[k];
                tmr_q[k]    <= tmr_d[k];
                steps_q[k]  <= steps_d[k];
                period_q[k] <= period_d[k];
                remain_q[k] <= remain_d[k];
            end
            dir_cfg_q <= dir_cfg_d;
            dir_q     <= dir_d;
            done_q    <= done_d;
            irq_en_q  <= irq_en_d;
            d_out_q   <= d_out_d;
        end
    end

endmodule

// File: doc/peripheral_motion_ctrl_mc.md
# peripheral_motion_ctrl_mc

Parametrised multi-channel motion-control peripheral for the control_motores subsystem. It sits on the 16-bit memory-mapped peripheral bus (cs/addr/rd/wr/d_in/d_out) and drives N_CH independent step/direction motor channels. Each channel has a programmable step count, step period and direction, started by a bitmask write. Per-channel busy/done status, abort and a maskable interrupt are provided.

## Interface
- N_CH, 4, number of motor channels (1..8)
- CNT_W, 16, step-count width (≤16)
- PER_W, 16, period width in clocks (≤16)
- PULSE_W, 4, step pulse high time in clocks (≥1)

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- d_in  in  16  bus write data
- cs  in  1  chip select
- addr  in  8  byte address; even addresses only, addr[0] ignored
- rd  in  1  read strobe
- wr  in  1  write strobe
- d_out  out  16  registered read data
- step  out  N_CH  step pulses
- dir  out  N_CH  direction, latched per move
- busy  out  N_CH  channel moving
- irq  out  1  OR over (done & irq_en)

## Operation
- Register map:
  - 0x00 CTRL: write bit k=1 starts channel k; bit 15=1 aborts all channels. Reads return the busy mask.
  - 0x02 DONE: sticky done flags; write-1-to-clear.
  - 0x04 IRQ_EN: mask (R/W).
  - Channel k base 0x10+8k:
    - +0 STEPS (R/W)
    - +2 PERIOD (R/W)
    - +4 DIR bit0 (R/W)
    - +6 REMAIN (read-only; steps left)
- Unmapped or out-of-range addresses: writes ignored, reads return 0. Unused high bits read 0.
- Access occurs on posedge when cs&wr (write) or cs&rd (read); cs&wr&rd together performs the write only.
- Writes to STEPS/PERIOD/DIR of a busy channel are ignored.
- Per-channel FSM: IDLE → HIGH → LOW → (HIGH | IDLE).
  - Start in IDLE with STEPS≠0: load REMAIN=STEPS, latch dir, go HIGH.
  - Start in IDLE with STEPS=0: stay IDLE, set done next cycle, no pulse.
  - HIGH: step=1 for PULSE_W clocks, then LOW.
  - LOW: step=0 for P_eff−PULSE_W clocks, where P_eff=max(PERIOD, 2·PULSE_W). Then decrement REMAIN; if the result is 0, go IDLE and set done, else go HIGH.
  - Start to a busy channel is ignored.
- Abort: every channel goes to IDLE next edge, step=0, done not set, REMAIN frozen at its current value.
  - Abort and start in the same write: abort wins, no channel starts.
- Done set and W1C clear in the same cycle: set wins.
- Channels are fully independent; simultaneous starts are allowed.

## Timing
- Reset values:
  - Outputs: d_out=0, step=0, dir=0, busy=0, irq=0.
  - Registers: all 0, all FSMs IDLE.
- Start written at edge t: busy=1 and step=1 from t+1; dir valid at t+1.
- Step rising edges are exactly P_eff clocks apart.
- Last pulse: its LOW phase ends at edge e; busy=0 and done=1 from e. irq follows done combinationally from the registered flags.
- Total move length: STEPS·P_eff clocks from t+1 to busy fall.
- Read: d_out updated at the edge where cs&rd is sampled, valid the following cycle; held otherwise.
- REMAIN counts down once per completed period. It reads STEPS−n after n full periods.
- rst mid-move: step low immediately (asynchronous); all state cleared.

## Test plan
- Reset/defaults: assert rst 50 ns mid-move. Expect step/busy/irq/d_out=0 asynchronously; a read of 0x10 returns 0.
- Single move: ch0 STEPS=24, PERIOD=20, DIR=1, write CTRL=0x0001.
  - Expect 24 pulses, each 4 clocks high, rising edges 20 clocks apart, dir0=1.
  - busy0 high for 480 clocks; then DONE reads 0x0001.
  - With IRQ_EN=1, irq=1 until W1C of 0x0001.
- Period clamp and zero steps: ch1 PERIOD=3 (PULSE_W=4), STEPS=2. Expect 8-clock pulse spacing.
  - ch2 STEPS=0 start: expect no pulse, busy2 never set, done2=1 next cycle.
- Concurrency and busy lockout: start ch0 (15 steps, period 10) and ch3 (11 steps, period 16) with CTRL=0x0009.
  - Writing ch0 STEPS=12 mid-move is ignored.
  - Each channel's pulse count and spacing is independent.
- Abort: start ch0 with 26 steps, period 10; write CTRL=0x8001 after 5 pulses.
  - Expect step0 low next cycle and busy=0; REMAIN reads 21; done0 stays 0; the same-cycle start bit is ignored.
- Bus edge cases:
  - Read of 0x48 with N_CH=4 returns 0.
  - Write with cs=0 has no effect.
  - A DONE W1C coinciding with a channel's final period end leaves done=1.
